// File: rtl/conv1d_cfu_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// conv1d_cfu_driver -- runs one conv1d job over the CFU command port:
// load inputs and kernel, set bias, start, wait, read results. Revision 1.0
// ============================================================================
module conv1d_cfu_driver #(
  parameter int IN_WORDS  = 4,
  parameter int KW_WORDS  = 2,
  parameter int OUT_WORDS = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [31:0] src_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [6:0]  cmd,
  output logic [31:0] inp0,
  output logic [31:0] inp1,
  input  logic        output_buffer_valid,
  input  logic [31:0] ret,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int MAX_IK  = (IN_WORDS > KW_WORDS) ? IN_WORDS : KW_WORDS;
  localparam int MAX_IKO = (MAX_IK > OUT_WORDS) ? MAX_IK : OUT_WORDS;
  localparam int MAX_ALL = (MAX_IKO > TIMEOUT) ? MAX_IKO : TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_WORDS - 1);
  localparam logic [CNT_W-1:0] KW_LAST  = CNT_W'(KW_WORDS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_WORDS - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0] CMD_NOP   = 7'd0;
  localparam logic [6:0] CMD_WR_IN = 7'd1;
  localparam logic [6:0] CMD_WR_KW = 7'd2;
  localparam logic [6:0] CMD_READ  = 7'd3;
  localparam logic [6:0] CMD_START = 7'd5;
  localparam logic [6:0] CMD_BIAS  = 7'd8;

  typedef enum logic [3:0] {
    IDLE, LOAD_IN, LOAD_KW, BIAS, START, WAIT, READ_REQ, READ_CAP, FIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] tcnt;
  logic [31:0]      bias_q;
  logic             to_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      tcnt      <= '0;
      bias_q    <= '0;
      to_flag   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bias_q  <= bias;
            idx     <= '0;
            to_flag <= 1'b0;
            state   <= LOAD_IN;
          end
        end
        LOAD_IN: begin
          if (src_valid) begin
            if (idx == IN_LAST) begin
              idx   <= '0;
              state <= LOAD_KW;
            end else begin
              idx <= idx + ONE;
            end
          end
        end
        LOAD_KW: begin
          if (src_valid) begin
            if (idx == KW_LAST) begin
              idx   <= '0;
              state <= BIAS;
            end else begin
              idx <= idx + ONE;
            end
          end
        end
        BIAS: state <= START;
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (output_buffer_valid) begin
            idx   <= '0;
            state <= READ_REQ;
          end else begin
            tcnt <= tcnt + ONE;
            if (tcnt == TO_LAST) begin
              to_flag <= 1'b1;
              state   <= FIN;
            end
          end
        end
        // Only issue a read once the result register is free (or freeing now).
        READ_REQ: begin
          if (!res_valid || res_ready) state <= READ_CAP;
        end
        READ_CAP: begin
          res_data  <= ret;
          res_valid <= 1'b1;
          idx       <= idx + ONE;
          state     <= (idx < OUT_LAST) ? READ_REQ : FIN;
        end
        FIN: begin
          if (!res_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command port is decoded from the state register so CFU writes coincide with the src handshake.
  always_comb begin
    cmd       = CMD_NOP;
    inp0      = '0;
    inp1      = '0;
    src_ready = 1'b0;
    case (state)
      LOAD_IN: begin
        src_ready = 1'b1;
        if (src_valid) begin
          cmd  = CMD_WR_IN;
          inp0 = 32'(idx);
          inp1 = src_data;
        end
      end
      LOAD_KW: begin
        src_ready = 1'b1;
        if (src_valid) begin
          cmd  = CMD_WR_KW;
          inp0 = 32'(idx);
          inp1 = src_data;
        end
      end
      BIAS: begin
        cmd  = CMD_BIAS;
        inp0 = bias_q;
      end
      START: cmd = CMD_START;
      READ_REQ: begin
        if (!res_valid || res_ready) begin
          cmd  = CMD_READ;
          inp0 = 32'(idx);
        end
      end
      default: ;
    endcase
  end

  assign busy        = (state != IDLE);
  assign done        = (state == FIN) && !res_valid;
  assign timeout_err = done && to_flag;

endmodule
`default_nettype wire

// File: tb/tb_conv1d_cfu_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_conv1d_cfu_driver -- scoreboard bench with a small CFU model. Revision 1.0
// ============================================================================
module tb_conv1d_cfu_driver;
  localparam int IN_WORDS  = 4;
  localparam int KW_WORDS  = 2;
  localparam int OUT_WORDS = 2;
  localparam int TIMEOUT   = 64;
  localparam int N_SRC     = IN_WORDS + KW_WORDS;

  logic        clk = 1'b0;
  logic        reset_n, start, src_valid, src_ready, res_valid, res_ready;
  logic        output_buffer_valid, busy, done, timeout_err;
  logic [31:0] bias, src_data, res_data, inp0, inp1;
  logic [31:0] ret = '0;
  logic [6:0]  cmd;

  conv1d_cfu_driver #(
    .IN_WORDS(IN_WORDS), .KW_WORDS(KW_WORDS), .OUT_WORDS(OUT_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bias(bias),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .output_buffer_valid(output_buffer_valid), .ret(ret),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    bit          ca;
    bit          cb;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] res_q[$];
  ent_t        e;
  logic [31:0] src_words [0:N_SRC-1];
  logic [31:0] ret_tab   [0:OUT_WORDS-1];
  logic        obv_en = 1'b1;
  int          cd = 0;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  int          done_cnt = 0, n_rd = 0, cmd5_cyc = 0, last_done_cyc = 0;
  logic        last_to = 1'b0;
  logic [31:0] exp_res;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // CFU model: result-ready three cycles after start, read data one cycle after cmd=3.
  always @(posedge clk) begin
    if (cmd == 7'd5) cd <= 3;
    else if (cd != 0) cd <= cd - 1;
    if (cmd == 7'd3) ret <= ret_tab[inp0[0]];
  end
  assign output_buffer_valid = obv_en && (cd == 1);

  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd != 7'd0) begin
        if (exp_q.size() == 0) begin
          chk("cmd_unexpected", 96'(cmd), 96'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_seq", {25'd0, cmd, e.ca ? inp0 : 32'd0, e.cb ? inp1 : 32'd0},
                         {25'd0, e.c, e.ca ? e.a : 32'd0, e.cb ? e.b : 32'd0});
        end
        if (cmd == 7'd5) cmd5_cyc = cyc;
        if (cmd == 7'd3) n_rd++;
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          chk("res_unexpected", 96'(res_q.size()), 96'd1);
        end else begin
          exp_res = res_q.pop_front();
          chk("res_data", 96'(res_data), 96'(exp_res));
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        last_to = timeout_err;
      end
    end
  end

  task automatic push_job(input logic [31:0] bias_v, input bit tout);
    for (int i = 0; i < IN_WORDS; i++) exp_q.push_back('{7'd1, 32'(i), src_words[i], 1'b1, 1'b1});
    for (int k = 0; k < KW_WORDS; k++) exp_q.push_back('{7'd2, 32'(k), src_words[IN_WORDS+k], 1'b1, 1'b1});
    exp_q.push_back('{7'd8, bias_v, 32'd0, 1'b1, 1'b0});
    exp_q.push_back('{7'd5, 32'd0, 32'd0, 1'b0, 1'b0});
    if (!tout) begin
      for (int r = 0; r < OUT_WORDS; r++) begin
        exp_q.push_back('{7'd3, 32'(r), 32'd0, 1'b1, 1'b0});
        res_q.push_back(ret_tab[r]);
      end
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      bit got;
      int t;
      if (toggle) begin @(posedge clk); #1; end
      src_valid = 1'b1;
      src_data  = src_words[i];
      got = 1'b0;
      t = 0;
      while (!got && t < 200) begin
        @(negedge clk); #1;
        if (src_ready) got = 1'b1;
        t++;
      end
      if (!got) chk("src_accept", 96'(got), 96'd1);
      @(posedge clk); #1 src_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < bound) begin @(posedge clk); t++; end
    chk(tag, 96'(done_cnt - d0), 96'd1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_cmd"},   96'(cmd), 96'd0);
    chk({tag, "_inp"},   {32'd0, inp0, inp1}, 96'd0);
    chk({tag, "_res"},   {63'd0, res_valid, res_data}, 96'd0);
    chk({tag, "_flags"}, {92'd0, src_ready, busy, done, timeout_err}, 96'd0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_expq"}, 96'(exp_q.size()), 96'd0);
    chk({tag, "_resq"}, 96'(res_q.size()), 96'd0);
  endtask

  initial begin
    int d0, snap, t;
    reset_n = 1'b0; start = 1'b0; bias = '0; src_valid = 1'b0; src_data = '0; res_ready = 1'b1;
    ret_tab[0] = 32'h1111_1111; ret_tab[1] = 32'h2222_2222;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 check_quiet("reset");
    reset_n = 1'b1;

    // Nominal job
    src_words = '{32'h0, 32'h0706_0504, 32'h0302_0100, 32'h0, 32'h0202_0202, 32'h0202_0202};
    bias = 32'd1;
    d0 = done_cnt;
    push_job(32'd1, 1'b0);
    start_pulse();
    feed(N_SRC, 1'b0);
    wait_done("nominal", 200);
    chk("nominal_to", 96'(last_to), 96'd0);
    check_drained("nominal");

    // Source valid toggling every other cycle
    src_words = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004, 32'hB0B0_0005, 32'hB0B0_0006};
    ret_tab[0] = 32'hA5A5_5A5A; ret_tab[1] = 32'h0F0F_F0F0;
    bias = 32'hCAFE_F00D;
    push_job(32'hCAFE_F00D, 1'b0);
    start_pulse();
    feed(N_SRC, 1'b1);
    wait_done("toggle", 200);
    check_drained("toggle");

    // Result back-pressure
    ret_tab[0] = 32'h1111_1111; ret_tab[1] = 32'h2222_2222;
    res_ready = 1'b0;
    push_job(32'hCAFE_F00D, 1'b0);
    start_pulse();
    feed(N_SRC, 1'b0);
    t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); #1; t++; end
    chk("hold_first_valid", 96'(res_valid), 96'd1);
    snap = n_rd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("hold_data", {63'd0, res_valid, res_data}, {63'd0, 1'b1, 32'h1111_1111});
      chk("hold_no_read", 96'(n_rd), 96'(snap));
    end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done("hold", 200);
    check_drained("hold");

    // Timeout: result-ready never raised
    obv_en = 1'b0;
    push_job(32'hCAFE_F00D, 1'b1);
    start_pulse();
    feed(N_SRC, 1'b0);
    wait_done("timeout", TIMEOUT + 50);
    chk("timeout_flag", 96'(last_to), 96'd1);
    chk("timeout_latency", 96'(last_done_cyc - cmd5_cyc), 96'(TIMEOUT + 1));
    @(negedge clk); #1 chk("timeout_idle", 96'(busy), 96'd0);
    check_drained("timeout");
    obv_en = 1'b1;

    // Reset during kernel load, then a clean job
    push_job(32'hCAFE_F00D, 1'b0);
    start_pulse();
    feed(IN_WORDS + 1, 1'b0);
    d0 = done_cnt;
    @(negedge clk); #2 reset_n = 1'b0;
    #1 check_quiet("abort");
    exp_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 96'(done_cnt), 96'(d0));
    push_job(32'hCAFE_F00D, 1'b0);
    start_pulse();
    feed(N_SRC, 1'b0);
    wait_done("post_abort", 200);
    check_drained("post_abort");

    // Start held high across two jobs; bias is latched per job
    d0 = done_cnt;
    bias = 32'h0000_0A0A;
    push_job(32'h0000_0A0A, 1'b0);
    push_job(32'h0000_0B0B, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 bias = 32'h0000_0B0B;
    feed(N_SRC, 1'b0);
    wait_done("held_a", 200);
    @(negedge clk); #1 chk("held_gap_idle", 96'(busy), 96'd0);
    @(negedge clk); #1 chk("held_restart", 96'(busy), 96'd1);
    @(posedge clk); #1 start = 1'b0;
    feed(N_SRC, 1'b0);
    wait_done("held_b", 200);
    repeat (4) @(negedge clk);
    #1 chk("held_single", {64'd0, 31'd0, busy, 32'(done_cnt - d0)}, {64'd0, 32'd2});
    check_drained("held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/conv1d_cfu_driver.md
CONV1D_CFU_DRIVER -- requirements
Module: conv1d_cfu_driver

Interface
REQ-001 Parameter IN_WORDS, 4, number of input-buffer words written per job, including padding words.
REQ-002 Parameter KW_WORDS, 2, number of kernel-weight words written per job.
REQ-003 Parameter OUT_WORDS, 2, number of output words read per job.
REQ-004 Parameter TIMEOUT, 64, maximum number of cycles to wait for output_buffer_valid.
REQ-005 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, job request; sampled only in IDLE.
REQ-008 Port bias, input, 32, bias value; latched when start is accepted.
REQ-009 Port src_valid / src_ready / src_data, in / out / in, 1 / 1 / 32, stream of IN_WORDS input words followed by KW_WORDS kernel words.
REQ-010 Port res_valid / res_ready / res_data, out / in / out, 1 / 1 / 32, stream of OUT_WORDS result words.
REQ-011 Port cmd, output, 7, command to the conv1d CFU.
REQ-012 Port inp0 / inp1, output, 32 each, CFU operands.
REQ-013 Port output_buffer_valid, input, 1, CFU result-ready flag.
REQ-014 Port ret, input, 32, CFU read data, valid one cycle after a cmd=3 is presented.
REQ-015 Port busy / done / timeout_err, output, 1 each; busy is high when the FSM is not in IDLE, done is a one-cycle pulse, timeout_err is a one-cycle pulse coincident with done.

Function
REQ-016 The CFU command codes SHALL be: 0 NOP, 1 write input word (inp0 = index, inp1 = data), 2 write kernel word (inp0 = index, inp1 = data), 8 set bias (inp0 = bias), 5 start, 3 read output (inp0 = index).
REQ-017 The FSM SHALL have the states IDLE, LOAD_IN, LOAD_KW, BIAS, START, WAIT, READ_REQ, READ_CAP and FIN.
REQ-018 IDLE: cmd = 0; on start = 1, latch bias, clear the index counter, and go to LOAD_IN.
REQ-019 LOAD_IN / LOAD_KW: src_ready = 1; each src_valid&src_ready cycle drives cmd = 1 / 2, inp0 = index, inp1 = src_data, and increments the index; when src_valid = 0, cmd = 0 and the index is held.
REQ-020 After index IN_WORDS-1 is written, the index SHALL reset to 0 and the FSM SHALL go to LOAD_KW; after index KW_WORDS-1 is written, the FSM SHALL go to BIAS.
REQ-021 BIAS SHALL drive cmd = 8 and inp0 = latched bias for exactly one cycle, then go to START.
REQ-022 START SHALL drive cmd = 5 for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-023 WAIT: cmd = 0; when output_buffer_valid = 1, clear the index and go to READ_REQ; otherwise increment the counter.
REQ-024 If the counter reaches TIMEOUT in WAIT, the FSM SHALL go to FIN with timeout_err flagged.
REQ-025 READ_REQ: when res_valid = 0, or res_valid&res_ready are both high, drive cmd = 3 and inp0 = index for one cycle and go to READ_CAP; otherwise drive cmd = 0 and stall.
REQ-026 READ_CAP: cmd = 0; register ret into res_data and set res_valid; increment the index; go to READ_REQ if index < OUT_WORDS-1, else go to FIN.
REQ-027 res_valid SHALL stay high, with res_data stable, until res_ready = 1.
REQ-028 FIN SHALL wait until res_valid = 0, then pulse done (and timeout_err if flagged) and return to IDLE.
REQ-029 src_ready SHALL be 0 in every state other than LOAD_IN and LOAD_KW.
REQ-030 start asserted while busy SHALL be ignored.
REQ-031 The index and timeout counters SHALL be wide enough for max(IN_WORDS, KW_WORDS, OUT_WORDS, TIMEOUT) without wrap-around.

Reset
REQ-032 reset_n = 0 SHALL immediately force IDLE and drive cmd = 0, inp0 = 0, inp1 = 0, src_ready = 0, res_valid = 0, res_data = 0, busy = 0, done = 0, timeout_err = 0, and clear all counters and the latched bias.
REQ-033 A reset during any state, including mid-load or mid-read, SHALL abort the job and emit no done pulse.

Verification
REQ-034 Nominal job: src words 0, 0x07060504, 0x03020100, 0, 0x02020202, 0x02020202; bias = 1; the CFU model raises output_buffer_valid 3 cycles after cmd=5 and returns 0x11111111 / 0x22222222 -> cmd sequence is 1,1,1,1 (inp0 = 0..3), 2,2 (inp0 = 0..1), 8 (inp0 = 1), 5, then 3 (inp0 = 0), 3 (inp0 = 1); res_data = 0x11111111 then 0x22222222; one done pulse, timeout_err = 0.
REQ-035 src_valid toggling every other cycle -> cmd = 0 on idle cycles, indices contiguous, no word lost or duplicated.
REQ-036 res_ready held low for 5 cycles after the first result -> res_data = 0x11111111 held stable, no second cmd=3 issued until that result is accepted.
REQ-037 output_buffer_valid never asserted -> done and timeout_err pulse together exactly TIMEOUT cycles after WAIT is entered, and the FSM returns to IDLE.
REQ-038 reset_n pulsed low during LOAD_KW -> all outputs 0 immediately, no done pulse; a subsequent job completes normally.
REQ-039 start held high for an entire job -> exactly one job per IDLE visit, and a second job starts on the cycle after done.
